// File: rtl/axi_stream_packet_arbiter_pkg.sv
// axi_stream_arb_pkg: shared types and helpers for the packet arbiter
package axi_stream_arb_pkg;
  typedef enum logic {IDLE, LOCK} state_t;
  function automatic int nsize(input int n);
    return n <= 2 ? 1 : n <= 4 ? 2 : n <= 8 ? 3 : n <= 16 ? 4 : 5;
  endfunction
  function automatic logic [31:0] bin2oh(input logic [4:0] b);
    return 32'd1 << b;
  endfunction
  function automatic logic [4:0] oh2bin(input logic [31:0] oh);
    oh2bin = '0;
    for (int i = 0; i < 32; i++) if (oh[i]) oh2bin = 5'(i);
  endfunction
endpackage

// File: rtl/axi_stream_packet_arbiter_pick.sv
// round_robin_pick: first set request bit searching upward from ptr+1, wrapping at NUM
module round_robin_pick
  import axi_stream_arb_pkg::*;
#(
  parameter int NUM = 8,
  parameter int NSIZE = nsize(NUM)
) (
  input  logic [NUM-1:0]   req,
  input  logic [NSIZE-1:0] ptr,
  output logic             found,
  output logic [NSIZE-1:0] idx
);
  logic [NUM-1:0] rot;
  int f;
  always_comb begin
    rot = NUM'({req, req} >> (int'(ptr) + 1));
    found = |rot;
    f = 0;
    for (int k = NUM - 1; k >= 0; k--) if (rot[k]) f = k;
    idx = NSIZE'((int'(ptr) + 1 + f) % NUM);
  end
endmodule

// File: rtl/axi_stream_packet_arbiter.sv
// axi_stream_packet_arbiter: packet-level round-robin select for the M2S interconnect,
// with per-grant burst rotation and a mid-packet stall watchdog
module axi_stream_packet_arbiter
  import axi_stream_arb_pkg::*;
#(
  parameter int NUM = 8,
  parameter int NSIZE = nsize(NUM),
  parameter int BURST = 1,
  parameter int TOUT = 1024
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [NUM-1:0]   s_tvalid,
  input  logic [NUM-1:0]   s_tready,
  input  logic [NUM-1:0]   s_tlast,
  input  logic [NUM-1:0]   req_mask,
  output logic [NSIZE-1:0] addr,
  output logic [NUM-1:0]   gate,
  output logic             grant_valid,
  output logic             timeout_pulse,
  output logic [NSIZE-1:0] timeout_id
);
  localparam int WW = TOUT > 0 ? $clog2(TOUT + 1) : 1;
  localparam logic [WW-1:0] TLIM = WW'(TOUT > 0 ? TOUT - 1 : 0);
  state_t state;
  logic [NSIZE-1:0] rr_ptr, idx;
  logic [7:0] bcnt;
  logic [WW-1:0] wcnt;
  logic [NUM-1:0] req;
  logic found, lock, eop, tmo, rotate;
  assign req = s_tvalid & req_mask;
  assign lock = state == LOCK;
  assign eop = lock && s_tvalid[addr] && s_tready[addr] && s_tlast[addr];
  // tmo needs tvalid low, so it can never coincide with eop
  assign tmo = TOUT > 0 && lock && !s_tvalid[addr] && wcnt == TLIM;
  assign rotate = tmo || (eop && (bcnt + 8'd1 == 8'(BURST) || !req[addr]));
  round_robin_pick #(.NUM(NUM), .NSIZE(NSIZE)) u_pick (
    .req(req),
    .ptr(lock ? addr : rr_ptr),
    .found(found),
    .idx(idx)
  );
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      gate <= '0;
      grant_valid <= 1'b0;
      timeout_pulse <= 1'b0;
      timeout_id <= '0;
      rr_ptr <= NSIZE'(NUM - 1);
      bcnt <= '0;
      wcnt <= '0;
    end else if (clk_en) begin
      timeout_pulse <= tmo;
      if (tmo) timeout_id <= addr;
      if (!lock || rotate) begin
        bcnt <= '0;
        wcnt <= '0;
        if (lock) rr_ptr <= addr;
        if (found) begin
          state <= LOCK;
          addr <= idx;
          gate <= NUM'(bin2oh(5'(idx)));
          grant_valid <= 1'b1;
        end else begin
          state <= IDLE;
          gate <= '0;
          grant_valid <= 1'b0;
        end
      end else begin
        if (eop) bcnt <= bcnt + 8'd1;
        wcnt <= s_tvalid[addr] ? '0 : wcnt == TLIM ? wcnt : wcnt + 1'b1;
      end
    end
endmodule

// File: doc/axi_stream_packet_arbiter.md
Name: axi_stream_packet_arbiter

Overview:
Packet-level round-robin arbiter that drives the `addr` select of the AXI-stream M2S interconnect. It observes the valid, ready and last handshake of each requester. Once a grant is made it is held until that packet's tlast is accepted. A watchdog releases a requester that stalls mid-packet. The block sits beside the M2S interconnect in the same clock domain and owns its select and gating.

Parameters:
NUM, 8, number of requesting streams (2..32)
NSIZE, NUM<=2?1:NUM<=4?2:NUM<=8?3:NUM<=16?4:5, addr width
BURST, 1, packets a requester may send per grant before rotation is forced (1..255)
TOUT, 1024, idle cycles of granted source mid-packet before forced release (0 = watchdog off)

Ports:
clock  in  1  system clock
rst  in  1  asynchronous, active-high reset
clk_en  in  1  global clock enable; all state holds when low
s_tvalid  in  NUM  per-requester axis_tvalid (raw)
s_tready  in  NUM  per-requester axis_tready after gating (as seen by the source)
s_tlast  in  NUM  per-requester axis_tlast
req_mask  in  NUM  1 = requester eligible; sampled only at arbitration
addr  out  NSIZE  select to the interconnect, registered
gate  out  NUM  one-hot grant; integration ANDs s00[i] tvalid/tready with gate[i]
grant_valid  out  1  high while a grant is held
timeout_pulse  out  1  one-cycle pulse on watchdog release
timeout_id  out  NSIZE  requester released by the last timeout; held until the next timeout

Behaviour:
- Reset values: addr=0, gate=0, grant_valid=0, timeout_pulse=0, timeout_id=0, state=IDLE, rr pointer=NUM-1 (first pick favours 0), burst count=0, watchdog=0.
- All registers update only when clk_en=1. Reset is asynchronous and overrides clk_en.
- Request vector: req = s_tvalid & req_mask.
- Pick rule: first set bit of req, searching upward from rr_ptr+1 modulo NUM.
- States:
  - IDLE: if req!=0, register the pick into addr/gate, set grant_valid=1, burst count=0, go to LOCK. Latency from request to gate is one cycle. If req=0, stay; gate=0.
  - LOCK, end-of-packet: eop = s_tvalid[addr] & s_tready[addr] & s_tlast[addr]. On eop, burst count increments.
  - LOCK, rotation on eop: if count+1==BURST, or the current source has no further req that cycle, set rr_ptr=addr and re-pick. Re-pick happens in the same cycle, so the new grant appears on the next cycle with no bubble. If no req remains, go to IDLE and clear gate/grant_valid. Otherwise stay with the same source.
  - LOCK, no eop: hold addr and gate unconditionally. Changes to req_mask and valid from other sources are ignored.
- Watchdog (TOUT>0): counts consecutive LOCK cycles with s_tvalid[addr]=0; it resets on any valid.
  - When count reaches TOUT: pulse timeout_pulse, set timeout_id=addr, set rr_ptr=addr, re-pick as on eop (burst count cleared).
  - The truncated packet is not repaired; the downstream sees a packet without tlast.
  - eop and timeout in the same cycle: eop wins, no pulse.
- Single requester with BURST=1: re-picks itself. gate stays continuous, no bubble.
- Reset asserted mid-packet: gate drops immediately (async); the packet is truncated.
- Watchdog counter width is clog2(TOUT+1) and saturates; the burst counter is 8 bits.

Decomposition:
- Package axi_stream_arb_pkg: state enum {IDLE, LOCK}, NSIZE-from-NUM constant function, one-hot/binary conversion functions.
- Sub-module round_robin_pick: combinational. Inputs req[NUM] and ptr[NSIZE]; outputs found and idx[NSIZE]. It is reused on both the IDLE and eop/timeout paths.

Test Plan:
- Reset: assert rst mid-run -> same cycle gate=0, grant_valid=0, addr=0. After release with req=0 -> all outputs stay 0.
- NUM=4, BURST=1, req=4'b0101 held, 3-beat packets -> addr sequence 0,2,0,2. On each tlast handshake the next cycle shows the new gate, with zero idle cycles between packets.
- Single requester 3, three 4-beat packets back-to-back -> gate=4'b1000 continuously for 12 cycles, grant_valid never drops.
- BURST=2, requesters 0 and 1 always valid, 2-beat packets -> packet order 0,0,1,1,0,0. req_mask[1] cleared mid-packet of 1 -> that packet completes, then only 0 is granted.
- TOUT=16, requester 1 sends 2 beats then drops valid without tlast, requester 2 waiting -> timeout_pulse high for exactly one cycle 16 cycles after the drop, timeout_id=1, gate=4'b0100 on the next cycle.
- clk_en=0 for 5 cycles during LOCK with a tlast handshake presented -> no state change or rotation. On the first cycle with clk_en=1 -> rotation occurs.
